dct_postifft_reod_1200out: RTL and testbench
============================================

// Module: dct_postIFFT_reod_1200out
// PURPOSE
//  Inverse of the DCT pre-FFT reorder. Sits right after the IFFT in the IDCT path.
//  Accepts one N-point frame in FFT order x0,x2,...,x(N-2),x(N-1),x(N-3),...,x3,x1.
//  Emits the 1200-sample window x(N-600),...,x(N-1),x1,...,x600 in natural order.
//  Single-frame buffer: one 2^wAddr-deep RAM of {real,imag}, write phase then read phase.
// PARAMETERS
//  wDataInOut  16    width of real and of imag
//  wAddr       11    RAM address width; N max = 2^wAddr
//  LEN_HALF    600   window half length; output frame = 2*LEN_HALF samples
// PORTS
//  clk           in   1        single clock, rising edge
//  rst_n         in   1        asynchronous, active-low reset
//  sink_valid    in   1        input sample valid
//  sink_ready    out  1        block accepts a sample when sink_valid&sink_ready
//  sink_error    in   2        ignored
//  sink_sop      in   1        first sample of frame
//  sink_eop      in   1        last sample of frame
//  sink_real     in   wDataInOut
//  sink_imag     in   wDataInOut
//  fftpts_in     in   12       N, sampled on the accepted sop
//  source_valid  out  1
//  source_ready  in   1        downstream backpressure
//  source_error  out  2        always 2'b00
//  source_sop    out  1        with 1st output sample
//  source_eop    out  1        with 1200th output sample
//  source_real   out  wDataInOut
//  source_imag   out  wDataInOut
//  fftpts_out    out  12       N latched for the current frame
//  frame_drop    out  1        1-cycle pulse when an input frame is discarded
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE. Takes effect immediately, mid-frame included; the partial frame is lost.
//  sink_ready: 1 in IDLE/WRITE, 0 in READ. Registered; rises on the first clk edge after reset release.
//  FSM:
//   IDLE : accept sink_valid&sink_sop -> latch N, write k=0, go WRITE. Non-sop samples are accepted and discarded.
//   WRITE: k = 0..N-1 counts accepted samples. Sample k is written to addr n:
//          n = 2k if k<N/2, else n = 2(N-1-k)+1.
//          Accept at k==N-1 with eop -> READ.
//          Drop -> frame_drop pulse, go IDLE: eop at k<N-1, sop at k>0, or k==N-1 without eop.
//          A drop caused by sop does not start a new frame.
//   READ : read addr seq N-LEN_HALF .. N-1, then 1 .. LEN_HALF (1200 reads).
//          After the eop sample is accepted -> IDLE.
//  N check at sop: N must be a power of 2 with 2*LEN_HALF < N <= 2^wAddr.
//   Otherwise the frame is consumed but dropped at its end (frame_drop, no output).
//  Output path: RAM read latency 1 cycle, then a 2-entry output skid buffer.
//   A read is issued in a cycle iff buffered + in-flight entries, minus the pop this cycle, are < 2.
//   With source_ready=1 throughout, the first source_valid comes 2 cycles after READ entry.
//   Output then runs 1200 consecutive cycles (1 sample/clk).
//   While source_valid&!source_ready, source_* data/sop/eop are held stable.
//   Backpressure never loses or duplicates a sample.
//  No zero-fill is needed: every output address lies in the written range.
//  fftpts_out updates at the accepted sop.
// TESTING
//  1 N=2048; input sample k real=mapped natural index n, imag=~n; source_ready=1
//    -> real = 1448..2047,1..600, imag matches; sop on 1st, eop on 1200th; valid contiguous.
//  2 Same frame, source_ready random 50%
//    -> identical 1200-sample sequence; outputs stable while stalled; sink_ready=0 until eop accepted.
//  3 eop at k=1000 -> frame_drop one pulse, no source_valid; next good frame gives test-1 output.
//  4 rst_n low for 1 cycle mid-READ (after 300 outputs)
//    -> all outputs 0 at once; next frame gives a full correct 1200 samples.
//  5 fftpts_in=1024 frame of 1024 samples -> frame_drop at its end, no output; sink_ready stays 1.
//  6 Back-to-back frames, sink_valid held high
//    -> second frame waits (sink_ready=0) and is output correctly after the first eop.

Source files
------------

// File: rtl/dct_postifft_reod_1200out.sv
// ---------------------------------------------------------------------------
// dct_postifft_reod_1200out
//
// Purpose
//   Inverse of the DCT pre-FFT reorder, placed right after the IFFT in the
//   IDCT path. One N-point frame arrives in FFT order
//     x0, x2, ..., x(N-2), x(N-1), x(N-3), ..., x3, x1
//   and is written to a single-frame RAM at its natural index. A window of
//   2*LEN_HALF samples is then read out in natural order:
//     x(N-LEN_HALF) .. x(N-1), x1 .. x(LEN_HALF)
//   The block alternates between a write phase and a read phase. It never
//   overlaps them.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   sink_valid/ready      input handshake; a sample is taken on valid & ready
//   sink_error            ignored
//   sink_sop/eop          frame delimiters of the input stream
//   sink_real/imag        input sample
//   fftpts_in             frame length N, sampled on the accepted start-of-frame
//   source_valid/ready    output handshake with downstream backpressure
//   source_error          tied to 2'b00
//   source_sop/eop        first / last sample of the output window
//   source_real/imag      output sample
//   fftpts_out            N of the current frame
//   frame_drop            one-cycle pulse when an input frame is discarded
// ---------------------------------------------------------------------------
module dct_postifft_reod_1200out #(
  parameter int wDataInOut = 16,
  parameter int wAddr      = 11,
  parameter int LEN_HALF   = 600
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sink_valid,
  output logic                  sink_ready,
  input  logic [1:0]            sink_error,
  input  logic                  sink_sop,
  input  logic                  sink_eop,
  input  logic [wDataInOut-1:0] sink_real,
  input  logic [wDataInOut-1:0] sink_imag,
  input  logic [11:0]           fftpts_in,
  output logic                  source_valid,
  input  logic                  source_ready,
  output logic [1:0]            source_error,
  output logic                  source_sop,
  output logic                  source_eop,
  output logic [wDataInOut-1:0] source_real,
  output logic [wDataInOut-1:0] source_imag,
  output logic [11:0]           fftpts_out,
  output logic                  frame_drop
);

  localparam int NW      = 12;
  localparam int DEPTH   = 1 << wAddr;
  localparam int OUT_LEN = 2 * LEN_HALF;
  localparam int CW      = $clog2(OUT_LEN + 1);
  localparam int DW      = 2 * wDataInOut;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } ent_t;

  // N must be a power of two, larger than the output window and fit the RAM.
  function automatic logic n_is_valid(input logic [NW-1:0] n);
    return ((n & (n - NW'(1))) == '0) && (n > NW'(OUT_LEN)) &&
           ({1'b0, n} <= (NW+1)'(DEPTH));
  endfunction

  // FFT-order position k -> natural index: evens ascending, then odds descending.
  function automatic logic [wAddr-1:0] wr_addr(input logic [NW-1:0] k,
                                               input logic [NW-1:0] n);
    logic [NW-1:0] a;
    if (k < (n >> 1)) a = k << 1;
    else              a = ((n - NW'(1) - k) << 1) | NW'(1);
    return a[wAddr-1:0];
  endfunction

  // Output position c -> natural index of the window.
  function automatic logic [wAddr-1:0] rd_addr(input logic [CW-1:0] c,
                                               input logic [NW-1:0] n);
    logic [NW-1:0] a;
    if (c < CW'(LEN_HALF)) a = n - NW'(LEN_HALF) + NW'(c);
    else                   a = NW'(c) - NW'(LEN_HALF) + NW'(1);
    return a[wAddr-1:0];
  endfunction

  state_t          state_q, state_d;
  logic            sink_ready_q, sink_ready_d;
  logic [NW-1:0]   k_q, k_d;
  logic [NW-1:0]   n_q, n_d;
  logic            n_ok_q, n_ok_d;
  logic            frame_drop_q, frame_drop_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            rd_vld_q, rd_vld_d;
  logic            rd_sop_q, rd_sop_d;
  logic            rd_eop_q, rd_eop_d;
  logic [1:0]      cnt_q, cnt_d;
  ent_t            e0_q, e0_d;
  ent_t            e1_q, e1_d;

  logic            accept;
  logic            pop;
  logic            re;
  logic            we;
  logic [wAddr-1:0] waddr;
  logic [wAddr-1:0] raddr;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   ram_q;
  logic [DW-1:0]   mem [DEPTH];
  ent_t            push_ent;
  logic            unused_sink_error;

  assign unused_sink_error = ^sink_error;

  assign accept = sink_valid & sink_ready_q;
  assign pop    = (cnt_q != 2'd0) & source_ready;
  assign wdata  = {sink_real, sink_imag};
  assign raddr  = rd_addr(rd_cnt_q, n_q);

  // A read is issued only if its data is guaranteed a free skid slot on return.
  always_comb begin
    re = (state_q == S_READ) && (rd_cnt_q < CW'(OUT_LEN)) &&
         (({1'b0, cnt_q} + {2'b00, rd_vld_q}) < (3'd2 + {2'b00, pop}));
  end

  // Write-phase / read-phase control
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    n_d          = n_q;
    n_ok_d       = n_ok_q;
    frame_drop_d = 1'b0;
    rd_cnt_d     = rd_cnt_q;
    we           = 1'b0;
    waddr        = wr_addr(k_q, n_q);
    case (state_q)
      S_IDLE: begin
        if (accept && sink_sop) begin
          n_d    = fftpts_in;
          n_ok_d = n_is_valid(fftpts_in);
          we     = 1'b1;
          waddr  = '0;
          // A one-sample frame or an immediate eop can never be a valid frame.
          if (sink_eop || (fftpts_in == NW'(1))) begin
            frame_drop_d = 1'b1;
          end else begin
            state_d = S_WRITE;
            k_d     = NW'(1);
          end
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (sink_sop) begin
            frame_drop_d = 1'b1;
            state_d      = S_IDLE;
          end else if (k_q == (n_q - NW'(1))) begin
            if (sink_eop && n_ok_q) begin
              we       = 1'b1;
              state_d  = S_READ;
              rd_cnt_d = '0;
            end else begin
              frame_drop_d = 1'b1;
              state_d      = S_IDLE;
            end
          end else if (sink_eop) begin
            frame_drop_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            we  = 1'b1;
            k_d = k_q + NW'(1);
          end
        end
      end
      S_READ: begin
        if (re) rd_cnt_d = rd_cnt_q + CW'(1);
        if (pop && e0_q.eop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    sink_ready_d = (state_d != S_READ);
    rd_vld_d     = re;
    rd_sop_d     = re && (rd_cnt_q == '0);
    rd_eop_d     = re && (rd_cnt_q == CW'(OUT_LEN - 1));
  end

  // Stage p0 -> p1: frame RAM, one-cycle registered read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) ram_q <= mem[raddr];
  end

  // Stage p1 -> p2: two-entry skid buffer, e0 is the head presented downstream
  always_comb begin
    push_ent.sop  = rd_sop_q;
    push_ent.eop  = rd_eop_q;
    push_ent.data = ram_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case ({rd_vld_q, pop})
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = push_ent;
        else               e1_d = push_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = push_ent;
        end else begin
          e0_d = e1_q;
          e1_d = push_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sink_ready_q <= 1'b0;
      k_q          <= '0;
      n_q          <= '0;
      n_ok_q       <= 1'b0;
      frame_drop_q <= 1'b0;
      rd_cnt_q     <= '0;
      rd_vld_q     <= 1'b0;
      rd_sop_q     <= 1'b0;
      rd_eop_q     <= 1'b0;
      cnt_q        <= '0;
      e0_q         <= '0;
      e1_q         <= '0;
    end else begin
      state_q      <= state_d;
      sink_ready_q <= sink_ready_d;
      k_q          <= k_d;
      n_q          <= n_d;
      n_ok_q       <= n_ok_d;
      frame_drop_q <= frame_drop_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_vld_q     <= rd_vld_d;
      rd_sop_q     <= rd_sop_d;
      rd_eop_q     <= rd_eop_d;
      cnt_q        <= cnt_d;
      e0_q         <= e0_d;
      e1_q         <= e1_d;
    end
  end

  assign sink_ready   = sink_ready_q;
  assign source_valid = (cnt_q != 2'd0);
  assign source_sop   = e0_q.sop & source_valid;
  assign source_eop   = e0_q.eop & source_valid;
  assign source_real  = e0_q.data[DW-1:wDataInOut];
  assign source_imag  = e0_q.data[wDataInOut-1:0];
  assign source_error = 2'b00;
  assign fftpts_out   = n_q;
  assign frame_drop   = frame_drop_q;

endmodule

// File: tb/tb_dct_postifft_reod_1200out.sv
// ---------------------------------------------------------------------------
// tb_dct_postifft_reod_1200out
//
// Bench for the post-IFFT reorder. Frames are built from a natural-order
// sample array, fed in FFT order, and the output window is predicted directly
// from the natural array. A scenario table covers good and discarded frames;
// hand-written sequences cover output latency, reset during readout and
// back-to-back frames.
// ---------------------------------------------------------------------------
module tb_dct_postifft_reod_1200out;

  localparam int LH   = 600;
  localparam int OUTN = 2 * LH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sink_valid = 1'b0;
  logic        sink_ready;
  logic [1:0]  sink_error = 2'b00;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [15:0] sink_real = '0;
  logic [15:0] sink_imag = '0;
  logic [11:0] fftpts_in = '0;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic [1:0]  source_error;
  logic        source_sop;
  logic        source_eop;
  logic [15:0] source_real;
  logic [15:0] source_imag;
  logic [11:0] fftpts_out;
  logic        frame_drop;

  dct_postifft_reod_1200out dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_error   (sink_error),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .fftpts_in    (fftpts_in),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_error (source_error),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_real  (source_real),
    .source_imag  (source_imag),
    .fftpts_out   (fftpts_out),
    .frame_drop   (frame_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] i;
    logic        sop;
    logic        eop;
    logic [11:0] pts;
  } smp_t;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] i;
    logic        sop;
    logic        eop;
  } osmp_t;

  typedef struct {
    int pts;
    int nsamp;
    int eop_at;
    int sop_at;
    bit idx_pat;
    bit rnd_ready;
    int exp_drops;
    int exp_outs;
  } row_t;

  smp_t  stim[$];
  osmp_t got[$];
  osmp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int drops = 0;
  int gaps = 0;
  int stall_bad = 0;
  int ready_waits = 0;
  bit rand_ready = 1'b0;
  bit in_frame = 1'b0;
  bit prev_stall = 1'b0;
  osmp_t prev_o;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Downstream ready: always 1 or a fair coin per cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      source_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: records accepted samples, drop pulses, gaps and stall stability.
  initial begin
    osmp_t cur;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        in_frame   = 1'b0;
      end else begin
        if (frame_drop) drops++;
        cur.r   = source_real;
        cur.i   = source_imag;
        cur.sop = source_sop;
        cur.eop = source_eop;
        if (prev_stall && (!source_valid || cur != prev_o)) stall_bad++;
        if (source_valid) begin
          if (source_ready) begin
            got.push_back(cur);
            if (source_sop) in_frame = 1'b1;
            if (source_eop) in_frame = 1'b0;
          end
          prev_stall = !source_ready;
          prev_o     = cur;
        end else begin
          prev_stall = 1'b0;
          if (in_frame && !rand_ready) gaps++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  // Build one input frame in FFT order and, if it is a good frame, its window.
  task automatic build_frame(input int pts, input int nsamp, input int eop_at,
                             input int sop_at, input bit idx_pat, input bit expect_out);
    logic [15:0] xr[];
    logic [15:0] xi[];
    int ord[$];
    smp_t s;
    osmp_t o;
    xr = new[pts];
    xi = new[pts];
    for (int n = 0; n < pts; n++) begin
      if (idx_pat) begin
        xr[n] = 16'(n);
        xi[n] = ~16'(n);
      end else begin
        xr[n] = 16'($urandom);
        xi[n] = 16'($urandom);
      end
    end
    for (int n = 0; n < pts; n += 2) ord.push_back(n);
    for (int n = pts - 1; n >= 1; n -= 2) ord.push_back(n);
    for (int k = 0; k < nsamp; k++) begin
      s.r   = xr[ord[k]];
      s.i   = xi[ord[k]];
      s.sop = (k == 0) || (k == sop_at);
      s.eop = (k == eop_at);
      s.pts = 12'(pts);
      stim.push_back(s);
    end
    if (expect_out) begin
      for (int n = pts - LH; n < pts; n++) begin
        o.r = xr[n]; o.i = xi[n]; o.sop = (n == pts - LH); o.eop = 1'b0;
        exp_q.push_back(o);
      end
      for (int n = 1; n <= LH; n++) begin
        o.r = xr[n]; o.i = xi[n]; o.sop = 1'b0; o.eop = (n == LH);
        exp_q.push_back(o);
      end
    end
  endtask

  task automatic drive_stream();
    smp_t s;
    int b;
    bit abort;
    abort = 1'b0;
    @(posedge clk);
    #1;
    while (stim.size() > 0 && !abort) begin
      s = stim.pop_front();
      sink_valid = 1'b1;
      sink_sop   = s.sop;
      sink_eop   = s.eop;
      sink_real  = s.r;
      sink_imag  = s.i;
      fftpts_in  = s.pts;
      sink_error = 2'($urandom);
      b = 0;
      @(negedge clk);
      while (!sink_ready && b < 5000) begin
        b++;
        ready_waits++;
        @(negedge clk);
      end
      if (!sink_ready) begin
        check("sink_accept_timeout", 0, 1);
        abort = 1'b1;
        stim.delete();
      end else begin
        @(posedge clk);
        #1;
      end
    end
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget);
    int c;
    c = 0;
    while (got.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic clear_run();
    got.delete();
    exp_q.delete();
    stim.delete();
    drops = 0;
    gaps = 0;
    stall_bad = 0;
    ready_waits = 0;
  endtask

  task automatic compare_outputs(input string name);
    int bad;
    int first;
    bad = 0;
    first = -1;
    check({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got.size() || got[i] != exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check({name, "_bad_samples"}, bad, 0);
    if (first >= 0 && first < got.size())
      $display("  first differing sample %0d: got %h required %h", first, got[first], exp_q[first]);
  endtask

  row_t rows[9];
  logic v0, v1, v2, s2, sr0;

  initial begin
    rows[0] = '{2048, 2048, 2047, -1, 1'b1, 1'b0, 0, OUTN};
    rows[1] = '{2048, 2048, 2047, -1, 1'b1, 1'b1, 0, OUTN};
    rows[2] = '{2048, 1001, 1000, -1, 1'b0, 1'b0, 1, 0};
    rows[3] = '{2048, 2048, 2047, -1, 1'b1, 1'b0, 0, OUTN};
    rows[4] = '{1024, 1024, 1023, -1, 1'b0, 1'b0, 1, 0};
    rows[5] = '{1536, 1536, 1535, -1, 1'b0, 1'b0, 1, 0};
    rows[6] = '{2048,  700,   -1, 500, 1'b0, 1'b0, 1, 0};
    rows[7] = '{2048, 2048,   -1, -1, 1'b0, 1'b0, 1, 0};
    rows[8] = '{2048, 2048, 2047, -1, 1'b0, 1'b1, 0, OUTN};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_source_valid", int'(source_valid), 0);
    check("reset_sink_ready", int'(sink_ready), 0);
    check("reset_fftpts_out", int'(fftpts_out), 0);
    check("reset_frame_drop", int'(frame_drop), 0);
    check("source_error", int'(source_error), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("sink_ready_after_release", int'(sink_ready), 1);

    // Scenario table
    for (int r = 0; r < 9; r++) begin
      clear_run();
      rand_ready = 1'b0;
      build_frame(rows[r].pts, rows[r].nsamp, rows[r].eop_at, rows[r].sop_at,
                  rows[r].idx_pat, rows[r].exp_outs != 0);
      rand_ready = rows[r].rnd_ready;
      drive_stream();
      if (rows[r].exp_outs != 0) wait_outputs(rows[r].exp_outs, 10000);
      repeat (40) @(negedge clk);
      check($sformatf("row%0d_drops", r), drops, rows[r].exp_drops);
      check($sformatf("row%0d_out_count", r), got.size(), rows[r].exp_outs);
      if (rows[r].exp_outs != 0) compare_outputs($sformatf("row%0d", r));
      check($sformatf("row%0d_stall_stability", r), stall_bad, 0);
      check($sformatf("row%0d_gaps", r), gaps, 0);
      check($sformatf("row%0d_sink_ready_waits", r), ready_waits, 0);
      if (rows[r].exp_outs != 0)
        check($sformatf("row%0d_fftpts_out", r), int'(fftpts_out), rows[r].pts);
    end
    rand_ready = 1'b0;

    // Output latency after READ entry and sink_ready during readout
    clear_run();
    build_frame(2048, 2048, 2047, -1, 1'b1, 1'b1);
    drive_stream();
    @(negedge clk); v0 = source_valid; sr0 = sink_ready;
    @(negedge clk); v1 = source_valid;
    @(negedge clk); v2 = source_valid; s2 = source_sop;
    check("latency_cycle0_valid", int'(v0), 0);
    check("latency_cycle1_valid", int'(v1), 0);
    check("latency_cycle2_valid", int'(v2), 1);
    check("latency_first_sop", int'(s2), 1);
    check("sink_ready_in_read", int'(sr0), 0);
    wait_outputs(OUTN, 5000);
    @(negedge clk);
    @(negedge clk);
    check("sink_ready_after_eop", int'(sink_ready), 1);
    compare_outputs("latency_frame");
    check("latency_frame_gaps", gaps, 0);

    // Reset asserted in the middle of readout
    clear_run();
    build_frame(2048, 2048, 2047, -1, 1'b0, 1'b0);
    drive_stream();
    wait_outputs(300, 5000);
    check("pre_reset_outputs_seen", int'(got.size() >= 300), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_source_valid", int'(source_valid), 0);
    check("midreset_sink_ready", int'(sink_ready), 0);
    check("midreset_data", int'({source_real, source_imag, source_sop, source_eop} != '0), 0);
    check("midreset_fftpts_out", int'(fftpts_out), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_run();
    build_frame(2048, 2048, 2047, -1, 1'b1, 1'b1);
    drive_stream();
    wait_outputs(OUTN, 5000);
    repeat (5) @(negedge clk);
    compare_outputs("after_reset");
    check("after_reset_drops", drops, 0);

    // Back-to-back frames with sink_valid held high
    clear_run();
    build_frame(2048, 2048, 2047, -1, 1'b0, 1'b1);
    build_frame(2048, 2048, 2047, -1, 1'b0, 1'b1);
    drive_stream();
    wait_outputs(2 * OUTN, 8000);
    repeat (5) @(negedge clk);
    compare_outputs("back_to_back");
    check("back_to_back_second_waited", int'(ready_waits > 0), 1);
    check("back_to_back_drops", drops, 0);
    check("back_to_back_gaps", gaps, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
